shift_register_universal: RTL and testbench

Parametrised WIDTH-bit register built on the same edge-triggered storage as the single-bit D flip-flop, extended with synchronous reset, hold, shift left/right, rotate and parallel load. It also tracks how many shifts have occurred since the last load or reset, so it can drive serialiser and deserialiser paths. It complements q with q_not, as the single-bit flip-flop does. It replaces ad-hoc chains of single-bit flip-flops wherever a multi-bit register with modes is needed.

---
 rtl/shift_register_universal.sv | 109 ++++++++++
 tb/tb_shift_register_universal.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_register_universal.sv
// shift_register_universal: WIDTH-bit register with hold, shift right/left,
// parallel load, synchronous active-high reset and a saturating shift counter
// that pulses done once per load/reset epoch when WIDTH shifts have happened.
// Optional feature macro: SHIFT_REG_ROTATE_EN (rotate input selects circular
// shifts). Without it the rotate port is present but has no effect.
// Parameter constraints: WIDTH >= 2, 2**CNT_W - 1 >= WIDTH.
module shift_register_universal #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             rotate,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_not,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             done
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHR   = 2'b01;
    localparam logic [1:0] MODE_SHL   = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             shr_in, shl_in;

`ifdef SHIFT_REG_ROTATE_EN
    // Serial inputs: wrap the outgoing bit back in when rotating.
    always_comb begin
        shr_in = rotate ? q_q[0]       : sin_r;
        shl_in = rotate ? q_q[WIDTH-1] : sin_l;
    end
`else
    logic unused_rotate;
    assign unused_rotate = rotate;

    // Serial inputs: rotation not built, always take the external bits.
    always_comb begin
        shr_in = sin_r;
        shl_in = sin_l;
    end
`endif

    // Next-state: register contents, shift counter and the done pulse.
    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        unique case (mode)
            MODE_HOLD: begin
                q_d = q_q;
            end
            MODE_SHR, MODE_SHL: begin
                if (mode == MODE_SHR) begin
                    q_d = {shr_in, q_q[WIDTH-1:1]};
                end else begin
                    q_d = {q_q[WIDTH-2:0], shl_in};
                end
                // Counter only climbs within an epoch, so WIDTH-1 -> WIDTH
                // happens at most once and done cannot re-fire.
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                done_d = (cnt_q == CNT_LAST);
            end
            MODE_LOAD: begin
                q_d   = d;
                cnt_d = '0;
            end
            default: begin
                q_d = q_q;
            end
        endcase
    end

    // State registers; reset overrides every mode including load.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // q_not is derived, never stored, so it cannot drift from q.
    assign q         = q_q;
    assign q_not     = ~q_q;
    assign sout_r    = q_q[0];
    assign sout_l    = q_q[WIDTH-1];
    assign shift_cnt = cnt_q;
    assign done      = done_q;

endmodule

// File: tb/tb_shift_register_universal.sv
// Directed bench for shift_register_universal (WIDTH=8, CNT_W=4).
module tb_shift_register_universal;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [1:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_r;
    logic             sin_l;
    logic             rotate;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_not;
    logic             sout_r;
    logic             sout_l;
    logic [CNT_W-1:0] shift_cnt;
    logic             done;

    int vectors;
    int miscompares;

    shift_register_universal #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .d         (d),
        .sin_r     (sin_r),
        .sin_l     (sin_l),
        .rotate    (rotate),
        .q         (q),
        .q_not     (q_not),
        .sout_r    (sout_r),
        .sout_l    (sout_l),
        .shift_cnt (shift_cnt),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [WIDTH-1:0] val);
        rst = 1'b0; mode = 2'b11; d = val;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; rotate = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mode  = 2'($urandom_range(0, 3));
            d     = 8'($urandom);
            sin_r = 1'($urandom);
            sin_l = 1'($urandom);
            tick();
        end
        rst = 1'b1; mode = 2'b10;
        tick();
        vectors++;
        if (q !== 8'h00 || q_not !== 8'hFF || shift_cnt !== 4'd0 || done !== 1'b0 ||
            sout_r !== 1'b0 || sout_l !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: q=%h q_not=%h cnt=%0d done=%b sr=%b sl=%b, want 00 ff 0 0 0 0",
                     q, q_not, shift_cnt, done, sout_r, sout_l);
        end
        rst = 1'b0; mode = 2'b00;
    endtask

    task automatic test_shift_right();
        logic [7:0] exp_sout;
        logic [7:0] exp_q;
        exp_sout = 8'b1010_0101; // bit i = sout_r before edge i (first at bit 7)
        load(8'hA5);
        exp_q = 8'hA5;
        mode = 2'b01; sin_r = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (sout_r !== exp_sout[7-i] || q_not !== ~exp_q || sout_l !== exp_q[7]) begin
                miscompares++;
                $display("FAIL shr_sout[%0d]: sout_r=%b q_not=%h sout_l=%b, want %b %h %b",
                         i, sout_r, q_not, sout_l, exp_sout[7-i], ~exp_q, exp_q[7]);
            end
            tick();
            exp_q = {1'b1, exp_q[7:1]};
            vectors++;
            if (q !== exp_q || shift_cnt !== 4'(i + 1) || done !== (i == 7)) begin
                miscompares++;
                $display("FAIL shr_step[%0d]: q=%h cnt=%0d done=%b, want %h %0d %b",
                         i, q, shift_cnt, done, exp_q, i + 1, (i == 7));
            end
        end
        mode = 2'b00;
        tick();
        vectors++;
        if (q !== 8'hFF || done !== 1'b0 || shift_cnt !== 4'd8) begin
            miscompares++;
            $display("FAIL shr_hold: q=%h done=%b cnt=%0d, want ff 0 8", q, done, shift_cnt);
        end
    endtask

    task automatic test_shift_left_sat();
        logic [7:0] exp_q;
        int         exp_cnt;
        int         done_seen;
        load(8'h01);
        exp_q = 8'h01; exp_cnt = 0; done_seen = 0;
        mode = 2'b10; sin_l = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_q   = {exp_q[6:0], 1'b0};
            exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
            if (done === 1'b1) done_seen++;
            vectors++;
            if (q !== exp_q || shift_cnt !== 4'(exp_cnt) || done !== (i == 7)) begin
                miscompares++;
                $display("FAIL shl_step[%0d]: q=%h cnt=%0d done=%b, want %h %0d %b",
                         i, q, shift_cnt, done, exp_q, exp_cnt, (i == 7));
            end
        end
        vectors++;
        if (done_seen != 1) begin
            miscompares++;
            $display("FAIL shl_done_count: got %0d pulses, want 1", done_seen);
        end
    endtask

    task automatic test_priority();
        load(8'h5A);
        rst = 1'b1; mode = 2'b11; d = 8'h3C;
        tick();
        rst = 1'b0;
        vectors++;
        if (q !== 8'h00 || shift_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL prio_rst_load: q=%h cnt=%0d, want 00 0", q, shift_cnt);
        end
        mode = 2'b00; d = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (q !== 8'h00 || shift_cnt !== 4'd0 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL prio_hold[%0d]: q=%h cnt=%0d done=%b, want 00 0 0",
                         i, q, shift_cnt, done);
            end
        end
    endtask

    // Mixed directions count once each; reset mid-sequence abandons it.
    task automatic test_back_to_back();
        load(8'h0F);
        mode = 2'b01; sin_r = 1'b1; tick();   // 87
        mode = 2'b10; sin_l = 1'b1; tick();   // 0f
        mode = 2'b10; sin_l = 1'b0; tick();   // 1e
        vectors++;
        if (q !== 8'h1E || shift_cnt !== 4'd3) begin
            miscompares++;
            $display("FAIL mixed_dir: q=%h cnt=%0d, want 1e 3", q, shift_cnt);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        mode = 2'b01; sin_r = 1'b0; tick();
        vectors++;
        if (q !== 8'h00 || shift_cnt !== 4'd1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: q=%h cnt=%0d done=%b, want 00 1 0", q, shift_cnt, done);
        end
    endtask

    task automatic test_rotate();
        logic [7:0] exp1, exp2, exp3;
`ifdef SHIFT_REG_ROTATE_EN
        exp1 = 8'hC0; exp2 = 8'h81; exp3 = 8'h03;
`else
        // Plain shifts with zero fill: 81>>1=40, 40<<1=80, 80<<1=00.
        exp1 = 8'h40; exp2 = 8'h80; exp3 = 8'h00;
`endif
        load(8'h81);
        rotate = 1'b1; sin_r = 1'b0; sin_l = 1'b0;
        mode = 2'b01; tick();
        vectors++;
        if (q !== exp1 || shift_cnt !== 4'd1) begin
            miscompares++;
            $display("FAIL rot_r: q=%h cnt=%0d, want %h 1", q, shift_cnt, exp1);
        end
        mode = 2'b10; tick();
        vectors++;
        if (q !== exp2) begin
            miscompares++;
            $display("FAIL rot_l1: q=%h, want %h", q, exp2);
        end
        tick();
        vectors++;
        if (q !== exp3 || shift_cnt !== 4'd3) begin
            miscompares++;
            $display("FAIL rot_l2: q=%h cnt=%0d, want %h 3", q, shift_cnt, exp3);
        end
        rotate = 1'b0; mode = 2'b00;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; mode = 2'b00; d = '0; sin_r = 1'b0; sin_l = 1'b0; rotate = 1'b0;
        tick();
        test_reset();
        test_shift_right();
        test_shift_left_sat();
        test_priority();
        test_back_to_back();
        test_rotate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
